// File: rtl/cla_addsub_pipe_pkg.sv
// Shared types and sizing helpers for the pipelined CLA adder/subtractor.
// Holds the width-independent part of a stage payload.
package cla_pkg;

    // Control bits that travel with every beat through the pipe.
    // c is the carry into the lowest block not yet resolved; after the
    // final stage it is the raw carry out of the MSB.
    typedef struct packed {
        logic valid;
        logic sat;
        logic a_msb;
        logic c;
        logic ovf;
    } cla_ctl_t;

    function automatic int num_blocks(input int n, input int blk);
        return n / blk;
    endfunction

    function automatic int blocks_per_stage(
        input int n,
        input int blk,
        input int stages
    );
        return (n / blk) / stages;
    endfunction

endpackage

// File: rtl/cla_addsub_pipe_if.sv
// Operand/result handshake bundle for cla_addsub_pipe.
// master drives operands and out_ready; slave is the adder itself.
interface cla_addsub_pipe_if #(
    parameter int N = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         sub;
    logic         sat;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;

    modport master (
        output in_valid, a, b, cin, sub, sat, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, sat, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

endinterface

// File: rtl/cla_addsub_pipe_blk_gp.sv
// Combinational BLK-bit carry-lookahead block.
// Ports: a, b, c_in in; sum, c_out, c_msb_in (carry into block MSB) out.
module cla_blk_gp #(
    parameter int BLK = 4
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           c_in,
    output logic [BLK-1:0] sum,
    output logic           c_out,
    output logic           c_msb_in
);

    logic [BLK-1:0] g;
    logic [BLK-1:0] p;
    logic [BLK-1:0] gg;
    logic [BLK-1:0] pp;
    logic [BLK:0]   c;

    always_comb begin
        g = a & b;
        p = a ^ b;
        // gg/pp[i] are group generate/propagate over bits i..0
        gg[0] = g[0];
        pp[0] = p[0];
        for (int i = 1; i < BLK; i++) begin
            gg[i] = g[i] | (p[i] & gg[i-1]);
            pp[i] = p[i] & pp[i-1];
        end
        c[0] = c_in;
        for (int i = 0; i < BLK; i++) begin
            c[i+1] = gg[i] | (pp[i] & c_in);
        end
        sum      = p ^ c[BLK-1:0];
        c_out    = c[BLK];
        c_msb_in = c[BLK-1];
    end

endmodule

// File: rtl/cla_addsub_pipe.sv
// Pipelined carry-lookahead add/subtract with valid/ready and saturation.
// Ports: clk, rst_n (async, active low), bus (slave side of handshake).
module cla_addsub_pipe
    import cla_pkg::*;
#(
    parameter int N      = 16,
    parameter int BLK    = 4,
    parameter int STAGES = 2
) (
    input logic              clk,
    input logic              rst_n,
    cla_addsub_pipe_if.slave bus
);

    localparam int NUM_BLOCKS = num_blocks(N, BLK);
    localparam int BPS        = blocks_per_stage(N, BLK, STAGES);

    localparam logic [N-1:0] SAT_POS = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] SAT_NEG = {1'b1, {(N-1){1'b0}}};

    // a/b keep the unresolved upper operand bits, s the resolved
    // lower sum bits; each stage fills in its own slice of s.
    typedef struct packed {
        cla_ctl_t     ctl;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] s;
    } stage_t;

    stage_t st_i [STAGES];
    stage_t st_d [STAGES];
    stage_t st_q [STAGES];

    logic [BLK-1:0] blk_s  [NUM_BLOCKS];
    logic           blk_co [NUM_BLOCKS];
    logic           blk_cm [NUM_BLOCKS];

    logic out_v;
    logic en;

    assign out_v = st_q[STAGES-1].ctl.valid;
    // One enable for the whole pipe: bubbles are held, never collapsed.
    assign en    = ~out_v | bus.out_ready;

    assign bus.in_ready  = en;
    assign bus.out_valid = out_v;
    assign bus.sum       = st_q[STAGES-1].s;
    assign bus.cout      = st_q[STAGES-1].ctl.c;
    assign bus.ovf       = st_q[STAGES-1].ctl.ovf;

    // Stage inputs: conditioned operands for stage 0, registers after.
    always_comb begin
        st_i[0].ctl.valid = bus.in_valid;
        st_i[0].ctl.sat   = bus.sat;
        st_i[0].ctl.a_msb = bus.a[N-1];
        // subtract is A + ~B + 1, so cin is ignored
        st_i[0].ctl.c     = bus.sub | bus.cin;
        st_i[0].ctl.ovf   = 1'b0;
        st_i[0].a         = bus.a;
        st_i[0].b         = bus.sub ? ~bus.b : bus.b;
        st_i[0].s         = '0;
        for (int k = 1; k < STAGES; k++) begin
            st_i[k] = st_q[k-1];
        end
    end

    for (genvar j = 0; j < NUM_BLOCKS; j++) begin : g_blk
        localparam int K = j / BPS;
        logic           c_in;
        logic           c_out;
        logic           c_msb;
        logic [BLK-1:0] s;

        if (j % BPS == 0) begin : g_head
            assign c_in = st_i[K].ctl.c;
        end else begin : g_chain
            assign c_in = g_blk[j-1].c_out;
        end

        cla_blk_gp #(
            .BLK(BLK)
        ) u_blk (
            .a       (st_i[K].a[j*BLK +: BLK]),
            .b       (st_i[K].b[j*BLK +: BLK]),
            .c_in    (c_in),
            .sum     (s),
            .c_out   (c_out),
            .c_msb_in(c_msb)
        );

        assign blk_s[j]  = s;
        assign blk_co[j] = c_out;
        assign blk_cm[j] = c_msb;
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            st_d[k] = st_i[k];
            for (int j = k * BPS; j < (k + 1) * BPS; j++) begin
                st_d[k].s[j*BLK +: BLK] = blk_s[j];
            end
            st_d[k].ctl.c = blk_co[(k+1)*BPS-1];
        end
        st_d[STAGES-1].ctl.ovf = blk_cm[NUM_BLOCKS-1]
                               ^ blk_co[NUM_BLOCKS-1];
        // Overflow means both effective operands share A's sign.
        if (st_d[STAGES-1].ctl.sat && st_d[STAGES-1].ctl.ovf) begin
            st_d[STAGES-1].s = st_d[STAGES-1].ctl.a_msb ? SAT_NEG
                                                        : SAT_POS;
        end
    end

    // Payload only loads with a valid beat; bubbles just clear valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                st_q[k] <= '0;
            end
        end else if (en) begin
            for (int k = 0; k < STAGES; k++) begin
                if (st_d[k].ctl.valid) begin
                    st_q[k] <= st_d[k];
                end else begin
                    st_q[k].ctl.valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Scoreboard bench for cla_addsub_pipe (N=16, BLK=4, STAGES=2).
// Directed vectors, stall, mid-flight reset and a random stream.
module tb_cla_addsub_pipe;

    localparam int N = 16;

    typedef struct packed {
        logic [N-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    cla_addsub_pipe_if #(.N(N)) bus ();

    cla_addsub_pipe #(
        .N     (N),
        .BLK   (4),
        .STAGES(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    exp_t sbq[$];
    int   tests    = 0;
    int   fails    = 0;
    int   rdy_mode = 0;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(
        input logic [N-1:0] s,
        input logic         c,
        input logic         o
    );
        exp_t e;
        e.sum  = s;
        e.cout = c;
        e.ovf  = o;
        return e;
    endfunction

    // Reference: plain wide addition, overflow from operand signs.
    function automatic exp_t model(
        input logic [N-1:0] a,
        input logic [N-1:0] b,
        input logic         cin,
        input logic         sub,
        input logic         sat
    );
        logic [N:0]   full;
        logic [N-1:0] be;
        exp_t         e;
        be     = sub ? ~b : b;
        full   = {1'b0, a} + {1'b0, be}
               + {{N{1'b0}}, (sub ? 1'b1 : cin)};
        e.sum  = full[N-1:0];
        e.cout = full[N];
        e.ovf  = (a[N-1] == be[N-1]) && (e.sum[N-1] != a[N-1]);
        if (sat && e.ovf) begin
            e.sum = a[N-1] ? {1'b1, {(N-1){1'b0}}}
                           : {1'b0, {(N-1){1'b1}}};
        end
        return e;
    endfunction

    // Called in the low clock phase; returns at the next negedge.
    task automatic send(
        input logic [N-1:0] a,
        input logic [N-1:0] b,
        input logic         cin,
        input logic         sub,
        input logic         sat,
        input exp_t         e
    );
        int n;
        n            = 0;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.sub      = sub;
        bus.sat      = sat;
        bus.in_valid = 1'b1;
        #1;
        while (!bus.in_ready && n < 1000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!bus.in_ready) begin
            tests++;
            fails++;
            $display("FAIL in_ready_timeout: got 0, expected 1");
        end else begin
            sbq.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", sbq.size(), 0);
    endtask

    // Sole driver of out_ready.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = 1'b0;
                default: bus.out_ready = ($urandom_range(3) != 0);
            endcase
        end
    end

    // Monitor: sample mid low phase, pop on each output transfer.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && bus.out_valid) begin
                if (sbq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: got sum %0h, expected none",
                             bus.sum);
                end else begin
                    chk("sum", 32'(bus.sum), 32'(sbq[0].sum));
                    chk("cout", 32'(bus.cout), 32'(sbq[0].cout));
                    chk("ovf", 32'(bus.ovf), 32'(sbq[0].ovf));
                    if (!bus.out_ready) begin
                        chk("in_ready_stall", 32'(bus.in_ready), 0);
                    end else begin
                        void'(sbq.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    logic [N-1:0] va [8];
    logic [N-1:0] vb [8];
    logic [N-1:0] ra;
    logic [N-1:0] rb;
    logic         rc;
    logic         rs;
    logic         rt;

    initial begin
        va = '{16'h1234, 16'h7FFF, 16'h8000, 16'hFFFF,
               16'h0F0F, 16'hA5A5, 16'h4000, 16'h0001};
        vb = '{16'h4321, 16'h7FFF, 16'h0001, 16'hFFFF,
               16'hF0F0, 16'h5A5A, 16'h4000, 16'h8000};
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.cin      = 1'b0;
        bus.sub      = 1'b0;
        bus.sat      = 1'b0;

        #12;
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_sum", 32'(bus.sum), 0);
        chk("rst_cout", 32'(bus.cout), 0);
        chk("rst_ovf", 32'(bus.ovf), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;

        send(16'h7FFF, 16'h0001, 0, 0, 0, mk(16'h8000, 0, 1));
        send(16'h7FFF, 16'h0001, 0, 0, 1, mk(16'h7FFF, 0, 1));
        send(16'h0005, 16'h0007, 0, 1, 0, mk(16'hFFFE, 0, 0));
        send(16'h8000, 16'h0001, 0, 1, 1, mk(16'h8000, 1, 1));
        send(16'hFFFF, 16'h0000, 1, 0, 0, mk(16'h0000, 1, 0));
        send(16'h0003, 16'h0003, 1, 1, 0, mk(16'h0000, 1, 0));
        send(16'h8000, 16'h8000, 0, 0, 1, mk(16'h8000, 1, 1));
        send(16'h00FF, 16'h0001, 0, 0, 0, mk(16'h0100, 0, 0));
        drain();

        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send(va[i], vb[i], i[1], i[0], i[2],
                         model(va[i], vb[i], i[1], i[0], i[2]));
                end
            end
            begin
                repeat (4) @(negedge clk);
                rdy_mode = 1;
                repeat (3) @(negedge clk);
                rdy_mode = 0;
            end
        join
        drain();

        send(16'h1234, 16'h1111, 0, 0, 0, mk(16'h2345, 0, 0));
        send(16'h0F0F, 16'h0101, 0, 0, 0, mk(16'h1010, 0, 0));
        rst_n = 1'b0;
        sbq.delete();
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 0);
        chk("midrst_sum", 32'(bus.sum), 0);
        chk("midrst_cout", 32'(bus.cout), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("postrst_in_ready", 32'(bus.in_ready), 1);
        send(16'h0001, 16'h0002, 0, 0, 0, mk(16'h0003, 0, 0));
        #1;
        chk("lat_cycle1_valid", 32'(bus.out_valid), 0);
        @(negedge clk);
        #1;
        chk("lat_cycle2_valid", 32'(bus.out_valid), 1);
        @(negedge clk);
        drain();

        rdy_mode = 2;
        for (int i = 0; i < 10000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            rs = 1'($urandom);
            rt = 1'($urandom);
            send(ra, rb, rc, rs, rt, model(ra, rb, rc, rs, rt));
        end
        rdy_mode = 0;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
